vm_change_dispenser: RTL and testbench
======================================

// Module: vm_change_dispenser
// PURPOSE
//  Downstream stage of the vending-machine core. It takes the refund/balance amount the core
//  releases at transaction end and pays it out as coins.
//  Keeps per-denomination coin-tube inventory and drives the coin ejector over a valid/ready
//  handshake. Reports any amount it could not pay (short) and an exact-change-only flag.
// PARAMETERS
//  BAL_W     16  width of change amount / short amount (cents)
//  TUBE_W     6  width of each tube counter
//  TUBE_MAX  63  tube capacity; refills saturate here
//  Q_VAL     25  quarter value;  D_VAL 10 dime value;  N_VAL 5 nickel value
// PORTS
//  clk           in   1       system clock, all logic on rising edge
//  rst           in   1       synchronous, active-high; full reset incl. tube counts
//  soft_rst      in   1       synchronous abort of current payout; tube counts preserved
//  change_req    in   1       request payout of change_amt (sampled when busy=0)
//  change_amt    in   BAL_W   amount to pay, cents
//  busy          out  1       1 from the cycle after acceptance until return to IDLE
//  coin_valid    out  1       ejector request
//  coin_type     out  2       01 nickel, 10 dime, 11 quarter (00 never driven with valid)
//  coin_ready    in   1       ejector accepts coin when coin_valid && coin_ready
//  done          out  1       1-cycle pulse at payout end
//  short_amt     out  BAL_W   unpaid remainder, valid from done until next acceptance
//  refill_valid  in   1       add one coin to tube refill_type
//  refill_type   in   2       same encoding as coin_type; 00 ignored
//  q_cnt,d_cnt,n_cnt out TUBE_W  tube inventories
//  exact_only    out  1       registered; 1 when n_cnt==0
// BEHAVIOUR
//  Reset (rst): state IDLE, busy/coin_valid/done/exact_only->0 then exact_only=1 next cycle,
//   coin_type=00, short_amt=0, remaining=0, all tube counts=0. rst has priority over soft_rst.
//  FSM (Moore outputs): IDLE, SELECT, EJECT, DONE.
//  IDLE: change_req=1 at cycle T -> remaining<=change_amt, state SELECT at T+1.
//   change_req while busy=1 is ignored (not queued).
//  SELECT (1 cycle): pick largest denom with value<=remaining and tube count>0 (Q, then D, then N).
//   Found -> EJECT. Else -> DONE with short_amt<=remaining (0 when remaining==0).
//  EJECT: coin_valid=1, coin_type stable while waiting; no change until coin_ready=1.
//   Handshake cycle: tube-1, remaining-=value, next state SELECT.
//   Max rate one coin per 2 cycles.
//  DONE: done=1 for exactly one cycle, then IDLE. Zero amount: accept at T, done at T+2.
//  Non-multiple-of-5 amounts: the remainder ends up in short_amt (e.g. 7 -> N paid, short 2).
//  remaining never underflows (denom only chosen if value<=remaining).
//  Refill: accepted in every state. Tube next = cnt - eject_hs + refill, saturating at TUBE_MAX.
//   Refill and eject of the same tube in one cycle: count unchanged, even at TUBE_MAX.
//   Refill landing in SELECT cycle counts from the next SELECT.
//  soft_rst: next cycle IDLE, coin_valid=0, busy=0, no done pulse.
//   Coins already handshaken stay debited; short_amt unchanged.
//   soft_rst concurrent with coin handshake: handshake completes (tube debited), then abort.
//  exact_only updates one cycle after n_cnt changes.
// TESTING
//  1 rst; refill 3Q,2D,2N; req 65, ready=1 -> coins Q,Q,D,N; done, short=0; Q=1,D=1,N=1.
//  2 Tubes Q0,D1,N0; req 30 -> one D ejected, done, short=20, d_cnt=0, exact_only=1.
//  3 ready held low 10 cycles in EJECT -> coin_valid/coin_type stable, counts/remaining unchanged;
//    ready=1 -> single debit.
//  4 q_cnt=63, refill Q -> stays 63. Refill Q on the same cycle as a Q handshake -> stays 63.
//    req 0 -> done at T+2, short 0.
//  5 soft_rst in EJECT (ready=0) -> next cycle coin_valid=0, busy=0, no done, counts kept;
//    new req 10 then paid normally.
//  6 req 7 with N available -> N ejected, short=2. req asserted while busy -> ignored.

Source files
------------

// File: rtl/vm_change_dispenser.sv
// Change dispenser: pays a refund amount as quarters/dimes/nickels from per-denomination
// coin tubes over a valid/ready ejector handshake, reporting any unpaid remainder.
module vm_change_dispenser #(
    parameter int BAL_W    = 16,
    parameter int TUBE_W   = 6,
    parameter int TUBE_MAX = 63,
    parameter int Q_VAL    = 25,
    parameter int D_VAL    = 10,
    parameter int N_VAL    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              soft_rst,
    input  logic              change_req,
    input  logic [BAL_W-1:0]  change_amt,
    output logic              busy,
    output logic              coin_valid,
    output logic [1:0]        coin_type,
    input  logic              coin_ready,
    output logic              done,
    output logic [BAL_W-1:0]  short_amt,
    input  logic              refill_valid,
    input  logic [1:0]        refill_type,
    output logic [TUBE_W-1:0] q_cnt,
    output logic [TUBE_W-1:0] d_cnt,
    output logic [TUBE_W-1:0] n_cnt,
    output logic              exact_only
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SELECT = 2'd1;
    localparam logic [1:0] S_EJECT  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [1:0] T_NICKEL  = 2'b01;
    localparam logic [1:0] T_DIME    = 2'b10;
    localparam logic [1:0] T_QUARTER = 2'b11;

    logic [1:0]       state;
    logic [BAL_W-1:0] remaining;
    logic [BAL_W-1:0] coin_val;
    logic             eject_hs;
    logic             pick_q, pick_d, pick_n;

    assign eject_hs   = (state == S_EJECT) && coin_ready;
    assign busy       = (state != S_IDLE);
    assign coin_valid = (state == S_EJECT);
    assign done       = (state == S_DONE);

    // Greedy choice: a denomination qualifies only if it fits in remaining, so no underflow.
    assign pick_q = (q_cnt != '0) && (remaining >= BAL_W'(Q_VAL));
    assign pick_d = (d_cnt != '0) && (remaining >= BAL_W'(D_VAL));
    assign pick_n = (n_cnt != '0) && (remaining >= BAL_W'(N_VAL));

    always_comb begin
        coin_val = '0;
        case (coin_type)
            T_QUARTER: coin_val = BAL_W'(Q_VAL);
            T_DIME:    coin_val = BAL_W'(D_VAL);
            T_NICKEL:  coin_val = BAL_W'(N_VAL);
            default:   coin_val = '0;
        endcase
    end

    // Simultaneous refill and eject of one tube cancel out, even when the tube is full.
    function automatic logic [TUBE_W-1:0] tube_next(input logic [TUBE_W-1:0] cnt,
                                                    input logic take, input logic add);
        if (add && !take)
            return (cnt == TUBE_W'(TUBE_MAX)) ? cnt : cnt + 1'b1;
        else if (take && !add)
            return cnt - 1'b1;
        else
            return cnt;
    endfunction

    // NOTE: all state, tube counters included, uses non-blocking assignments so every
    // register samples the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            remaining  <= '0;
            coin_type  <= 2'b00;
            short_amt  <= '0;
            q_cnt      <= '0;
            d_cnt      <= '0;
            n_cnt      <= '0;
            exact_only <= 1'b0;
        end else begin
            q_cnt <= tube_next(q_cnt, eject_hs && (coin_type == T_QUARTER),
                               refill_valid && (refill_type == T_QUARTER));
            d_cnt <= tube_next(d_cnt, eject_hs && (coin_type == T_DIME),
                               refill_valid && (refill_type == T_DIME));
            n_cnt <= tube_next(n_cnt, eject_hs && (coin_type == T_NICKEL),
                               refill_valid && (refill_type == T_NICKEL));
            exact_only <= (n_cnt == '0);

            if (soft_rst) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (change_req) begin
                            remaining <= change_amt;
                            state     <= S_SELECT;
                        end
                    end
                    S_SELECT: begin
                        if (pick_q) begin
                            coin_type <= T_QUARTER;
                            state     <= S_EJECT;
                        end else if (pick_d) begin
                            coin_type <= T_DIME;
                            state     <= S_EJECT;
                        end else if (pick_n) begin
                            coin_type <= T_NICKEL;
                            state     <= S_EJECT;
                        end else begin
                            short_amt <= remaining;
                            state     <= S_DONE;
                        end
                    end
                    S_EJECT: begin
                        if (coin_ready) begin
                            remaining <= remaining - coin_val;
                            state     <= S_SELECT;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vm_change_dispenser.sv
// Self-checking bench for vm_change_dispenser: directed table, hand-written corner
// sequences and randomized payouts against a greedy arithmetic reference model.
module tb_vm_change_dispenser;

    logic        clk = 1'b0;
    logic        rst, soft_rst, change_req, coin_ready, refill_valid;
    logic [15:0] change_amt;
    logic [1:0]  refill_type;
    logic        busy, coin_valid, done, exact_only;
    logic [1:0]  coin_type;
    logic [15:0] short_amt;
    logic [5:0]  q_cnt, d_cnt, n_cnt;

    int total = 0;
    int bad   = 0;

    vm_change_dispenser dut (
        .clk(clk), .rst(rst), .soft_rst(soft_rst),
        .change_req(change_req), .change_amt(change_amt),
        .busy(busy), .coin_valid(coin_valid), .coin_type(coin_type),
        .coin_ready(coin_ready), .done(done), .short_amt(short_amt),
        .refill_valid(refill_valid), .refill_type(refill_type),
        .q_cnt(q_cnt), .d_cnt(d_cnt), .n_cnt(n_cnt), .exact_only(exact_only)
    );

    always #5 clk = ~clk;

    typedef struct {
        int amt;
        int q, d, n;
        int eq, ed, en;
        int esh;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic refill(input logic [1:0] t, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            refill_valid = 1'b1;
            refill_type  = t;
            tick();
        end
        refill_valid = 1'b0;
        refill_type  = 2'b00;
    endtask

    task automatic load_tubes(input int q, input int d, input int n);
        refill(2'b11, q);
        refill(2'b10, d);
        refill(2'b01, n);
        tick();
    endtask

    task automatic wait_done(output int sh);
        bit seen = 0;
        sh = -1;
        for (int c = 0; c < 400 && !seen; c++) begin
            tick();
            if (done) begin
                seen = 1;
                sh   = int'(short_amt);
            end
        end
        check("done_reached", int'(seen), 1);
    endtask

    // Requests amt and runs the payout to its done pulse, counting coins per type.
    task automatic pay(input int amt, input bit rand_ready, input bit hold_req,
                       output int nq, output int nd, output int nn, output int sh);
        bit seen = 0;
        nq = 0; nd = 0; nn = 0; sh = -1;
        change_amt = 16'(amt);
        change_req = 1'b1;
        tick();
        if (hold_req) change_amt = 16'd50;
        else          change_req = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
            coin_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (coin_valid && coin_ready) begin
                case (coin_type)
                    2'b11:   nq++;
                    2'b10:   nd++;
                    2'b01:   nn++;
                    default: check("coin_type_nonzero", int'(coin_type), 1);
                endcase
            end
            tick();
            if (done) begin
                seen = 1;
                sh   = int'(short_amt);
            end
        end
        change_req = 1'b0;
        coin_ready = 1'b0;
        check("pay_done_reached", int'(seen), 1);
    endtask

    int nq, nd, nn, sh, unstable, pulses;
    int mq, md, mn, amt, rem, gq, gd, gn;

    initial begin
        rst = 1'b0; soft_rst = 1'b0; change_req = 1'b0; change_amt = '0;
        coin_ready = 1'b0; refill_valid = 1'b0; refill_type = 2'b00;

        vecs[0] = '{65,  3, 2, 2, 2, 1, 1, 0};
        vecs[1] = '{30,  0, 1, 0, 0, 1, 0, 20};
        vecs[2] = '{7,   0, 0, 1, 0, 0, 1, 2};
        vecs[3] = '{0,   1, 1, 1, 0, 0, 0, 0};
        vecs[4] = '{40,  1, 0, 5, 1, 0, 3, 0};
        vecs[5] = '{100, 2, 3, 0, 2, 3, 0, 20};
        vecs[6] = '{3,   5, 5, 5, 0, 0, 0, 3};

        // Reset state
        do_reset();
        check("rst_busy", int'(busy), 0);
        check("rst_coin_valid", int'(coin_valid), 0);
        check("rst_done", int'(done), 0);
        check("rst_coin_type", int'(coin_type), 0);
        check("rst_short", int'(short_amt), 0);
        check("rst_exact_only", int'(exact_only), 0);
        tick();
        check("rst_exact_only_next", int'(exact_only), 1);

        // Directed table
        foreach (vecs[i]) begin
            do_reset();
            check("tbl_rst_q", int'(q_cnt), 0);
            check("tbl_rst_n", int'(n_cnt), 0);
            load_tubes(vecs[i].q, vecs[i].d, vecs[i].n);
            check("tbl_exact_only", int'(exact_only), (vecs[i].n == 0) ? 1 : 0);
            pay(vecs[i].amt, 1'b0, 1'b0, nq, nd, nn, sh);
            check("tbl_coins_q", nq, vecs[i].eq);
            check("tbl_coins_d", nd, vecs[i].ed);
            check("tbl_coins_n", nn, vecs[i].en);
            check("tbl_short", sh, vecs[i].esh);
            check("tbl_q_cnt", int'(q_cnt), vecs[i].q - vecs[i].eq);
            check("tbl_d_cnt", int'(d_cnt), vecs[i].d - vecs[i].ed);
            check("tbl_n_cnt", int'(n_cnt), vecs[i].n - vecs[i].en);
        end

        // Ejector stall: outputs and counts hold until ready, then a single debit
        do_reset();
        load_tubes(1, 0, 0);
        change_amt = 16'd25; change_req = 1'b1; tick(); change_req = 1'b0;
        tick();
        check("stall_valid", int'(coin_valid), 1);
        unstable = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (coin_valid !== 1'b1 || coin_type !== 2'b11 || q_cnt !== 6'd1 || done !== 1'b0)
                unstable++;
        end
        check("stall_stable", unstable, 0);
        coin_ready = 1'b1; tick(); coin_ready = 1'b0;
        check("stall_single_debit", int'(q_cnt), 0);
        check("stall_valid_drop", int'(coin_valid), 0);
        wait_done(sh);
        check("stall_short", sh, 0);

        // Tube saturation, refill+eject cancel at full, zero-amount latency
        do_reset();
        refill(2'b11, 64);
        check("sat_q_63", int'(q_cnt), 63);
        change_amt = 16'd25; change_req = 1'b1; tick(); change_req = 1'b0;
        tick();
        coin_ready = 1'b1; refill_valid = 1'b1; refill_type = 2'b11;
        tick();
        coin_ready = 1'b0; refill_valid = 1'b0; refill_type = 2'b00;
        check("sat_refill_eject", int'(q_cnt), 63);
        wait_done(sh);
        tick();
        change_amt = 16'd0; change_req = 1'b1; tick(); change_req = 1'b0;
        check("zero_t1_done", int'(done), 0);
        check("zero_t1_busy", int'(busy), 1);
        tick();
        check("zero_t2_done", int'(done), 1);
        check("zero_short", int'(short_amt), 0);
        tick();
        check("zero_t3_done", int'(done), 0);
        check("zero_t3_busy", int'(busy), 0);

        // soft_rst while stalled in EJECT, then during a handshake
        do_reset();
        load_tubes(0, 2, 0);
        change_amt = 16'd10; change_req = 1'b1; tick(); change_req = 1'b0;
        tick();
        check("soft_in_eject", int'(coin_valid), 1);
        soft_rst = 1'b1; tick(); soft_rst = 1'b0;
        check("soft_valid", int'(coin_valid), 0);
        check("soft_busy", int'(busy), 0);
        check("soft_d_kept", int'(d_cnt), 2);
        pulses = int'(done);
        for (int i = 0; i < 4; i++) begin
            tick();
            pulses += int'(done);
        end
        check("soft_no_done", pulses, 0);
        pay(10, 1'b0, 1'b0, nq, nd, nn, sh);
        check("soft_after_d", nd, 1);
        check("soft_after_short", sh, 0);
        check("soft_after_dcnt", int'(d_cnt), 1);
        tick();
        change_amt = 16'd10; change_req = 1'b1; tick(); change_req = 1'b0;
        tick();
        coin_ready = 1'b1; soft_rst = 1'b1; tick(); coin_ready = 1'b0; soft_rst = 1'b0;
        check("soft_hs_debit", int'(d_cnt), 0);
        check("soft_hs_busy", int'(busy), 0);
        check("soft_hs_short_kept", int'(short_amt), 0);

        // Odd amount with request held high throughout: extra request ignored
        do_reset();
        load_tubes(0, 0, 1);
        pay(7, 1'b0, 1'b1, nq, nd, nn, sh);
        check("odd_n", nn, 1);
        check("odd_short", sh, 2);
        tick();
        check("ignored_busy1", int'(busy), 0);
        tick();
        check("ignored_busy2", int'(busy), 0);
        check("ignored_n_cnt", int'(n_cnt), 0);

        // Randomized payouts against a greedy model of the tube contents
        do_reset();
        mq = 0; md = 0; mn = 0;
        for (int it = 0; it < 30; it++) begin
            for (int r = $urandom_range(0, 12); r > 0; r--) begin
                refill_valid = 1'b1;
                refill_type  = 2'($urandom_range(0, 3));
                case (refill_type)
                    2'b11: if (mq < 63) mq++;
                    2'b10: if (md < 63) md++;
                    2'b01: if (mn < 63) mn++;
                    default: ;
                endcase
                tick();
            end
            refill_valid = 1'b0; refill_type = 2'b00;
            tick();
            check("rnd_exact_only", int'(exact_only), (mn == 0) ? 1 : 0);
            amt = $urandom_range(0, 150);
            rem = amt;
            gq = (rem / 25 < mq) ? rem / 25 : mq; rem -= 25 * gq;
            gd = (rem / 10 < md) ? rem / 10 : md; rem -= 10 * gd;
            gn = (rem / 5  < mn) ? rem / 5  : mn; rem -= 5 * gn;
            pay(amt, 1'b1, 1'b0, nq, nd, nn, sh);
            mq -= gq; md -= gd; mn -= gn;
            check("rnd_coins", nq * 10000 + nd * 100 + nn, gq * 10000 + gd * 100 + gn);
            check("rnd_short", sh, rem);
            check("rnd_tubes", int'(q_cnt) * 10000 + int'(d_cnt) * 100 + int'(n_cnt),
                  mq * 10000 + md * 100 + mn);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
